// File: rtl/pprm_pkg.sv
// Shared types, constants and GF(2^4) arithmetic for the PPRM pipeline.
// Field polynomial x^4+x+1; zero has no inverse and is mapped to zero.
package pprm_pkg;

    typedef logic [3:0] gf16_t;

    localparam logic [4:0] GF16_POLY = 5'b10011;

    // The state value doubles as the occupancy count; without the skid
    // buffer ST_ONE plays the role of FULL and ST_TWO is never reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        gf16_t a;
        gf16_t b;
        gf16_t d;
    } entry_t;

    function automatic gf16_t gf16_mul(input gf16_t x, input gf16_t y);
        gf16_t acc;
        gf16_t sh;
        acc = '0;
        sh  = x;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[3] ? ({sh[2:0], 1'b0} ^ GF16_POLY[3:0]) : {sh[2:0], 1'b0};
        end
        return acc;
    endfunction

    // The multiplicative group has order 15, so c^-1 = c^14 = c^2*c^4*c^8.
    function automatic gf16_t gf16_inv(input gf16_t c);
        gf16_t c2;
        gf16_t c4;
        gf16_t c8;
        c2 = gf16_mul(c, c);
        c4 = gf16_mul(c2, c2);
        c8 = gf16_mul(c4, c4);
        return gf16_mul(gf16_mul(c2, c4), c8);
    endfunction

endpackage

// File: rtl/gf16_inv_comb.sv
// Purely combinational GF(2^4) inverter (x^4+x+1); 0 maps to 0.
module gf16_inv_comb
    import pprm_pkg::*;
(
    input  logic [3:0] c_in,
    output logic [3:0] d_out
);

    assign d_out = gf16_inv(c_in);

endmodule

// File: rtl/pprm_stage_2.sv
// PPRM stage 2: forwards A/B and registers D = C^-1 behind a valid/ready pipe.
// Define PPRM_STAGE2_SKID_EN for the 2-entry skid buffer; default is 1 entry.
module pprm_stage_2
    import pprm_pkg::*;
#(
    parameter int unsigned ZERO_ON_IDLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [3:0] out_d,
    output logic [1:0] occupancy
);

    // Handshake: a transfer happens on a side only in a cycle where that
    // side's valid and ready are both 1; out_valid/data hold until taken.

    occ_state_e state_q, state_d;
    entry_t     head_q, head_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       accept;
    logic       xfer;
    gf16_t      d_new;
    entry_t     new_entry;

    gf16_inv_comb u_inv (
        .c_in  (in_c),
        .d_out (d_new)
    );

    assign new_entry = '{a: in_a, b: in_b, d: d_new};
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid_q & out_ready;

`ifdef PPRM_STAGE2_SKID_EN
    entry_t skid_q, skid_d;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    head_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = ST_TWO;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if ((ZERO_ON_IDLE != 0) && (state_d == ST_EMPTY)) begin
            head_d = '0;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end
`else
    // in_ready_q only marks "out of reset"; readiness itself is combinational.
    assign in_ready = in_ready_q & (~out_valid_q | out_ready);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept) begin
                    head_d = new_entry;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if ((ZERO_ON_IDLE != 0) && (state_d == ST_EMPTY)) begin
            head_d = '0;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = head_q.a;
    assign out_b     = head_q.b;
    assign out_d     = head_q.d;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pprm_stage_2.sv
// Bench for pprm_stage_2: directed scenarios plus a randomized stall run
// scored against a queue model; covers both PPRM_STAGE2_SKID_EN builds.
module tb_pprm_stage_2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b, in_c;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a, out_b, out_d;
    logic [1:0] occupancy;

    int n_chk = 0;
    int n_bad = 0;
    int n_acc = 0;
    bit edge_seen = 1'b0;
    logic [11:0] exp_q[$];
    logic [3:0] tbl [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                             4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

    always #5 clk = ~clk;

    pprm_stage_2 #(.ZERO_ON_IDLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_d     (out_d),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inverse found by searching for d with c*d == 1 using polynomial
    // multiplication and reduction by x^4+x+1.
    function automatic logic [3:0] ref_inv(input logic [3:0] c);
        int p;
        for (int d = 1; d < 16; d++) begin
            p = 0;
            for (int i = 0; i < 4; i++) begin
                if (c[i]) p = p ^ (d << i);
            end
            for (int k = 6; k >= 4; k--) begin
                if (p[k]) p = p ^ (19 << (k - 4));
            end
            if (p == 1) return 4'(d);
        end
        return 4'h0;
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        out_ready = ordy;
    endtask

    task automatic sample_model();
        int   cnt;
        logic ov_exp;
        logic rdy_exp;
        cnt    = exp_q.size();
        ov_exp = (cnt > 0);
`ifdef PPRM_STAGE2_SKID_EN
        rdy_exp = edge_seen && (cnt != 2);
`else
        rdy_exp = edge_seen && (!ov_exp || out_ready);
`endif
        chk("out_valid", 32'(out_valid), 32'(ov_exp));
        chk("occupancy", 32'(occupancy), 32'(cnt));
        chk("in_ready", 32'(in_ready), 32'(rdy_exp));
        if (ov_exp) chk("out_data", 32'({out_a, out_b, out_d}), 32'(exp_q[0]));
        else        chk("idle_zero", 32'({out_a, out_b, out_d}), 32'd0);
        if (ov_exp && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy_exp) begin
            exp_q.push_back({in_a, in_b, ref_inv(in_c)});
            n_acc++;
        end
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic ordy);
        drive(v, a, b, c, ordy);
        @(negedge clk);
        sample_model();
    endtask

    task automatic tick();
        @(posedge clk);
        edge_seen = 1'b1;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            tick();
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cycles;
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        #1;
        sample_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sample_model();
        tick();
        chk("rdy_after_release", 32'(in_ready), 32'd1);

        // Exhaustive inverse table with out_ready held high.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step(1'b1, 4'h5, 4'hA, i[3:0], 1'b1);
            else        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            if (i > 0) begin
                chk("tbl_valid", 32'(out_valid), 32'd1);
                chk("tbl_d", 32'(out_d), 32'(tbl[i-1]));
                chk("tbl_a", 32'(out_a), 32'h5);
                chk("tbl_b", 32'(out_b), 32'hA);
            end
            tick();
        end
        drain();

        // Backpressure.
        step(1'b1, 4'h1, 4'h2, 4'h3, 1'b0);
        tick();
`ifdef PPRM_STAGE2_SKID_EN
        step(1'b1, 4'h1, 4'h2, 4'h8, 1'b0);
        tick();
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_rdy", 32'(in_ready), 32'd0);
        chk("bp_d", 32'(out_d), 32'hE);
        tick();
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("bp_hold", 32'(out_d), 32'hE);
        tick();
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("bp_first", 32'(out_d), 32'hE);
        tick();
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("bp_second", 32'(out_d), 32'hF);
        tick();
`else
        step(1'b1, 4'h1, 4'h2, 4'h8, 1'b0);
        chk("ns_full_rdy", 32'(in_ready), 32'd0);
        chk("ns_occ", 32'(occupancy), 32'd1);
        tick();
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("ns_rdy_follow", 32'(in_ready), 32'd1);
        chk("ns_d", 32'(out_d), 32'hE);
        tick();
`endif
        drain();

        // Streaming: 16 back-to-back items.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i[3:0], 1'b1);
            else        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            if (i > 0) begin
                chk("stream_occ", 32'(occupancy), 32'd1);
                chk("stream_ov", 32'(out_valid), 32'd1);
            end
            tick();
        end
        drain();

        // Reset while entries are held.
        step(1'b1, 4'h7, 4'h7, 4'h3, 1'b0);
        tick();
        step(1'b1, 4'h7, 4'h7, 4'h8, 1'b0);
        tick();
        step(1'b1, 4'h7, 4'h7, 4'h9, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_data", 32'({out_a, out_b, out_d}), 32'd0);
        exp_q.delete();
        edge_seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sample_model();
        tick();
        chk("rst_rdy_rise", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            tick();
        end

        // Random stall run.
        n_acc  = 0;
        cycles = 0;
        while (n_acc < 10000 && cycles < 60000) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
            tick();
            cycles++;
        end
        chk("rand_items", 32'(n_acc), 32'd10000);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
